// File: rtl/ssdec_scan.sv
// ssdec_scan: sequential binary-to-BCD seven-segment driver with free-running digit scan.
// Define SSDEC_LZB_EN to blank leading zero digits.
module ssdec_scan #(
  parameter int WIDTH    = 9,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   segments,
  output logic [DIGITS-1:0]     digit_sel,
  output logic [6:0]            seg_out
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [63:0] LIM = 64'(10 ** DIGITS);
  localparam logic [6:0] DASH = 7'b1000000;
`ifdef SSDEC_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    shift_q, shift_d;
  logic [BW-1:0]       bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_p_q, ovf_p_d;
  logic                overflow_q, overflow_d;
  logic                done_q, done_d;
  logic [7*DIGITS-1:0] segments_q, segments_d, seg_new;
  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic                presc_wrap, seen;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0: seg7 = 7'b0111111;
      4'd1: seg7 = 7'b0000110;
      4'd2: seg7 = 7'b1011011;
      4'd3: seg7 = 7'b1001111;
      4'd4: seg7 = 7'b1100110;
      4'd5: seg7 = 7'b1101101;
      4'd6: seg7 = 7'b1111101;
      4'd7: seg7 = 7'b0000111;
      4'd8: seg7 = 7'b1111111;
      4'd9: seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_p_d    = ovf_p_q;
    overflow_d = overflow_q;
    segments_d = segments_q;
    done_d     = 1'b0;
    seen       = 1'b0;
    bcd_adj    = '0;
    seg_new    = '0;
    for (int i = 0; i < DIGITS; i++)
      bcd_adj[4*i+:4] = bcd_q[4*i+:4] >= 4'd5 ? bcd_q[4*i+:4] + 4'd3 : bcd_q[4*i+:4];
    // scan from the top so each digit knows whether anything nonzero sits above it
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen = seen | (bcd_q[4*i+:4] != 4'd0);
      seg_new[7*i+:7] = ovf_p_q ? DASH : (LZB && !seen && i != 0) ? 7'd0 : seg7(bcd_q[4*i+:4]);
    end
    case (state_q)
      IDLE: if (start) begin
        shift_d = value;
        bcd_d   = '0;
        cnt_d   = '0;
        ovf_p_d = 64'(value) >= LIM;
        state_d = CONV;
      end
      CONV: begin
        bcd_d   = {bcd_adj[BW-2:0], shift_q[WIDTH-1]};
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + CW'(1);
        state_d = cnt_q == CW'(WIDTH - 1) ? UPDATE : CONV;
      end
      UPDATE: begin
        segments_d = seg_new;
        overflow_d = ovf_p_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    presc_wrap  = presc_q == PW'(SCAN_DIV - 1);
    presc_d     = presc_wrap ? '0 : presc_q + PW'(1);
    idx_d       = !presc_wrap ? idx_q : (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
    digit_sel_d = DIGITS'(1) << idx_d;
    seg_out     = '0;
    for (int i = 0; i < DIGITS; i++)
      seg_out = idx_q == IW'(i) ? segments_q[7*i+:7] : seg_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      ovf_p_q     <= 1'b0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
      segments_q  <= '0;
      presc_q     <= '0;
      idx_q       <= '0;
      digit_sel_q <= DIGITS'(1);
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      ovf_p_q     <= ovf_p_d;
      overflow_q  <= overflow_d;
      done_q      <= done_d;
      segments_q  <= segments_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign segments  = segments_q;
  assign digit_sel = digit_sel_q;
endmodule
